pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width; power of two, 4..64.
REQ-002 The block SHALL have parameter AMT_W, default 8: shift-amount width; 2**AMT_W >= WIDTH.
REQ-003 The block SHALL have localparam LAT = $clog2(WIDTH): pipeline depth in cycles.
REQ-004 The block SHALL have clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have in_valid  input  1  request present.
REQ-007 The block SHALL have in_ready  output  1  block accepts request this cycle.
REQ-008 The block SHALL have data_in  input  WIDTH  operand.
REQ-009 The block SHALL have amt  input  AMT_W  unsigned shift amount.
REQ-010 The block SHALL have mode  input  2  shift_mode_t operation select.
REQ-011 The block SHALL have out_valid  output  1  result present.
REQ-012 The block SHALL have out_ready  input  1  consumer accepts result.
REQ-013 The block SHALL have data_out  output  WIDTH  shifted result.
REQ-014 The block SHALL have zero  output  1  data_out == 0.

Function
REQ-015 Modes SHALL be LSL=0 (logical left, zero fill), LSR=1 (logical right, zero fill), ASR=2 (arithmetic right, sign fill), ROR=3 (rotate right).
REQ-016 A request SHALL be accepted on a cycle with in_valid && in_ready.
REQ-017 The result SHALL appear on data_out with out_valid=1 exactly LAT cycles after acceptance when no stall occurs; throughput SHALL be one result per cycle.
REQ-018 Stage k (k=0..LAT-1) SHALL register the intermediate, conditionally shifted by 2**k when amt bit k is set, and SHALL carry mode, the remaining amt bits and a valid bit forward.
REQ-019 For LSL/LSR with amt >= WIDTH, the result SHALL be all zeros.
REQ-020 For ASR with amt >= WIDTH, the result SHALL be all copies of data_in[WIDTH-1].
REQ-021 For ROR, the effective amount SHALL be amt mod WIDTH; amt=0 or any multiple of WIDTH SHALL return data_in unchanged.
REQ-022 amt=0 SHALL return data_in unchanged in every mode.
REQ-023 zero SHALL be registered alongside data_out and valid only while out_valid=1; it SHALL be 0 otherwise.
REQ-024 Stall: in_ready SHALL equal !out_valid || out_ready; when in_ready=0 the whole pipeline, including data_out, out_valid and zero, SHALL hold every register.
REQ-025 Bubbles (in_valid=0 while in_ready=1) SHALL propagate as invalid stages; results SHALL never be duplicated, dropped or reordered.
REQ-026 in_ready SHALL be 1 whenever out_valid=0, including while the pipeline holds only bubbles.
REQ-027 Inputs sampled while in_ready=0 SHALL be ignored.

Reset
REQ-028 While rst=1 on a rising clk edge, all stage valid bits and out_valid SHALL clear to 0, data_out SHALL clear to 0 and zero SHALL clear to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight requests; no result SHALL emerge for them after rst deasserts.
REQ-030 in_ready SHALL be 1 in the first cycle after reset.
REQ-031 Stage data registers other than data_out need not be reset.

Structure
REQ-032 Package barrel_pkg SHALL hold the shift_mode_t enum (LSL, LSR, ASR, ROR) and any shared width constants.
REQ-033 One sub-module, shift_stage, parametrised by WIDTH and stage distance, SHALL implement a single registered conditional shift with stall enable; the top SHALL instantiate LAT copies via generate.

Verification
Each scenario uses WIDTH=8 and LAT=3 unless noted.
REQ-034 LSL 0x23 amt=3 -> data_out=0x18, zero=0, out_valid exactly 3 cycles after accept.
REQ-035 ROR 0x23 amt=1, then amt=9 back-to-back -> 0x91 on two consecutive cycles.
REQ-036 ASR 0xA3 amt=2 -> 0xE8; ASR 0xA3 amt=8 -> 0xFF; LSR 0xA3 amt=9 -> 0x00 with zero=1.
REQ-037 Stream amt=1..16 LSL on 0x23 with out_ready low for 4 cycles mid-stream -> in_ready drops, data_out holds, all 16 results arrive in order with none lost.
REQ-038 Assert rst for one cycle with 3 requests in flight -> out_valid stays 0 until the next accepted request completes.
REQ-039 WIDTH=32, ROR 0x2383_2CD0 amt=16 -> 0x2CD0_2383, delivered 5 cycles after accept.

Source files
------------

// File: rtl/pipelined_barrel_shifter_pkg.sv
// barrel_pkg: shared operation encoding for the pipelined barrel shifter
package barrel_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROR = 2'd3
  } shift_mode_t;
endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: request/result handshake bundle of the barrel shifter
interface pipelined_barrel_shifter_if
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amt;
  shift_mode_t      mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             zero;
  modport master (
    output in_valid, data_in, amt, mode, out_ready,
    input  in_ready, out_valid, data_out, zero
  );
  modport slave (
    input  in_valid, data_in, amt, mode, out_ready,
    output in_ready, out_valid, data_out, zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// shift_stage: one registered conditional shift by DIST, consuming the low amount bit
module shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  shift_mode_t      mode_i,
  input  logic [SH_W-1:0]  amt_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output shift_mode_t      mode_o,
  output logic [SH_W-1:0]  amt_o,
  output logic             zero_o
);
  logic             valid_q, zero_q;
  logic [WIDTH-1:0] data_q, data_d, asr;
  shift_mode_t      mode_q;
  logic [SH_W-1:0]  amt_q;
  // shift by DIST in the selected mode when the current amount bit is set
  always_comb begin
    asr    = $signed(data_i) >>> DIST;
    data_d = !amt_i[0]      ? data_i :
             mode_i == LSL  ? data_i << DIST :
             mode_i == LSR  ? data_i >> DIST :
             mode_i == ASR  ? asr :
                              (data_i >> DIST) | (data_i << (WIDTH - DIST));
  end
  // stage register; frozen while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      mode_q  <= LSL;
      amt_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      zero_q  <= valid_i && data_d == '0;
      mode_q  <= mode_i;
      amt_q   <= amt_i >> 1;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign mode_o  = mode_q;
  assign amt_o   = amt_q;
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-stage shifter with valid/ready flow control
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input logic clk,
  input logic rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int LAT = $clog2(WIDTH);
  logic                        en, big, unused;
  logic [LAT:0]                v_s;
  logic [LAT:0][WIDTH-1:0]     d_s;
  shift_mode_t [LAT:0]         m_s;
  logic [LAT:0][LAT-1:0]       a_s;
  logic [LAT-1:0]              z_s;
  assign en           = !v_s[LAT] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = v_s[LAT];
  assign bus.data_out = d_s[LAT];
  assign bus.zero     = z_s[LAT-1];
  assign big          = {1'b0, bus.amt} >= (AMT_W + 1)'(WIDTH);
  assign v_s[0]       = bus.in_valid;
  assign m_s[0]       = bus.mode;
  assign a_s[0]       = bus.amt[LAT-1:0];
  // oversized non-rotate shifts saturate up front; the stages then leave the value unchanged
  assign d_s[0] = big && bus.mode != ROR ?
                  (bus.mode == ASR ? {WIDTH{bus.data_in[WIDTH-1]}} : '0) : bus.data_in;
  for (genvar k = 0; k < LAT; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .DIST(1 << k), .SH_W(LAT)) u_stage (
      .clk(clk), .rst(rst), .en_i(en),
      .valid_i(v_s[k]), .data_i(d_s[k]), .mode_i(m_s[k]), .amt_i(a_s[k]),
      .valid_o(v_s[k+1]), .data_o(d_s[k+1]), .mode_o(m_s[k+1]), .amt_o(a_s[k+1]),
      .zero_o(z_s[k])
    );
  end
  assign unused = ^{m_s[LAT], a_s[LAT], z_s[LAT-2:0]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed vectors with a queue scoreboard and decoupled monitor
module tb_pipelined_barrel_shifter;
  import barrel_pkg::*;
  typedef struct { logic [31:0] d; logic z; int due; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  exp_t q8[$], q32[$];
  logic [7:0] held;
  logic [7:0] stream_exp [16] = '{8'h46, 8'h8C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  pipelined_barrel_shifter_if #(.WIDTH(8), .AMT_W(8)) b8();
  pipelined_barrel_shifter_if #(.WIDTH(32), .AMT_W(8)) b32();
  pipelined_barrel_shifter #(.WIDTH(8), .AMT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  pipelined_barrel_shifter #(.WIDTH(32), .AMT_W(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endfunction
  task automatic send8(input logic [7:0] d, input logic [7:0] a, input shift_mode_t m,
                       input logic [7:0] e, input bit lat);
    int n = 0;
    b8.data_in = d; b8.amt = a; b8.mode = m; b8.in_valid = 1'b1;
    @(negedge clk);
    while (!b8.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (b8.in_ready) q8.push_back('{{24'h0, e}, e == 8'h00, lat ? cyc + 3 : -1});
    else chk("accept8_timeout", 32'(b8.in_ready), 32'd1);
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
  endtask
  task automatic send32(input logic [31:0] d, input logic [7:0] a, input shift_mode_t m,
                        input logic [31:0] e);
    int n = 0;
    b32.data_in = d; b32.amt = a; b32.mode = m; b32.in_valid = 1'b1;
    @(negedge clk);
    while (!b32.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (b32.in_ready) q32.push_back('{e, e == 32'h0, cyc + 5});
    else chk("accept32_timeout", 32'(b32.in_ready), 32'd1);
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!b8.out_valid) chk("zero8_idle", 32'(b8.zero), 32'd0);
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out8_unexpected actual=%0h required=none", b8.data_out);
        end else begin
          e = q8.pop_front();
          chk("data8", 32'(b8.data_out), e.d);
          chk("zero8", 32'(b8.zero), 32'(e.z));
          if (e.due >= 0) chk("latency8", cyc, e.due);
        end
      end
      if (!b32.out_valid) chk("zero32_idle", 32'(b32.zero), 32'd0);
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out32_unexpected actual=%0h required=none", b32.data_out);
        end else begin
          e = q32.pop_front();
          chk("data32", b32.data_out, e.d);
          chk("zero32", 32'(b32.zero), 32'(e.z));
          chk("latency32", cyc, e.due);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    b8.in_valid = 1'b0; b8.data_in = '0; b8.amt = '0; b8.mode = LSL; b8.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.data_in = '0; b32.amt = '0; b32.mode = LSL; b32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
    chk("rst_data_out", 32'(b8.data_out), 32'd0);
    chk("rst_zero", 32'(b8.zero), 32'd0);
    chk("rst_in_ready", 32'(b8.in_ready), 32'd1);
    chk("rst_out_valid32", 32'(b32.out_valid), 32'd0);
    chk("rst_data_out32", b32.data_out, 32'd0);
    @(posedge clk);
    #1;
    send8(8'h23, 8'd3, LSL, 8'h18, 1'b1);
    send8(8'h23, 8'd1, ROR, 8'h91, 1'b1);
    send8(8'h23, 8'd9, ROR, 8'h91, 1'b1);
    send8(8'hA3, 8'd2, ASR, 8'hE8, 1'b1);
    send8(8'hA3, 8'd8, ASR, 8'hFF, 1'b1);
    send8(8'hA3, 8'd9, LSR, 8'h00, 1'b1);
    send8(8'hA3, 8'd0, LSL, 8'hA3, 1'b1);
    send8(8'hA3, 8'd0, LSR, 8'hA3, 1'b1);
    send8(8'hA3, 8'd0, ASR, 8'hA3, 1'b1);
    send8(8'hA3, 8'd0, ROR, 8'hA3, 1'b1);
    send8(8'hA3, 8'd8, ROR, 8'hA3, 1'b1);
    send8(8'hA3, 8'd255, ROR, 8'h47, 1'b1);
    send8(8'hA3, 8'd7, LSR, 8'h01, 1'b1);
    send8(8'h23, 8'd255, ASR, 8'h00, 1'b1);
    send8(8'hA3, 8'd8, LSL, 8'h00, 1'b1);
    send8(8'hA3, 8'd4, ASR, 8'hFA, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    send8(8'h01, 8'd7, LSL, 8'h80, 1'b1);
    send8(8'h81, 8'd1, ROR, 8'hC0, 1'b1);
    fork
      for (int i = 0; i < 16; i++) send8(8'h23, 8'(i + 1), LSL, stream_exp[i], 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1 b8.out_ready = 1'b0;
        @(negedge clk);
        held = b8.data_out;
        chk("stall_out_valid", 32'(b8.out_valid), 32'd1);
        chk("stall_in_ready", 32'(b8.in_ready), 32'd0);
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold", 32'(b8.data_out), 32'(held));
          chk("stall_in_ready", 32'(b8.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 b8.out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 200 && q8.size() != 0; n++) @(negedge clk);
    chk("drain8", q8.size(), 32'd0);
    @(posedge clk);
    #1 b8.out_ready = 1'b0;
    send8(8'h23, 8'd1, LSL, 8'h46, 1'b1);
    send8(8'h23, 8'd2, LSL, 8'h8C, 1'b1);
    send8(8'h23, 8'd3, LSL, 8'h18, 1'b1);
    rst = 1'b1;
    q8.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    b8.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(b8.in_ready), 32'd1);
    chk("flush_data_out", 32'(b8.data_out), 32'd0);
    repeat (4) begin
      chk("flush_out_valid", 32'(b8.out_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send8(8'h23, 8'd4, LSL, 8'h30, 1'b1);
    send32(32'h2383_2CD0, 8'd16, ROR, 32'h2CD0_2383);
    send32(32'h8000_0000, 8'd40, ASR, 32'hFFFF_FFFF);
    send32(32'h0000_0001, 8'd31, LSL, 32'h8000_0000);
    send32(32'h2383_2CD0, 8'd32, LSR, 32'h0000_0000);
    for (int n = 0; n < 200 && (q8.size() != 0 || q32.size() != 0); n++) @(negedge clk);
    chk("drain8_final", q8.size(), 32'd0);
    chk("drain32_final", q32.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
